// File: rtl/vdp_io_pkg.sv
// Shared types and constants for the VDP I/O port decoder slice.
package vdp_io_pkg;

  localparam int VRAM_AW_DEF = 17;

  typedef enum logic [1:0] {
    PORT_DATA = 2'd0,
    PORT_CTRL = 2'd1,
    PORT_PAL  = 2'd2,
    PORT_IND  = 2'd3
  } vdp_port_e;

  // Registers the decoder shadows locally.
  localparam logic [5:0] REG_ADDR_HI  = 6'd14;
  localparam logic [5:0] REG_STAT_SEL = 6'd15;
  localparam logic [5:0] REG_PAL_IDX  = 6'd16;
  localparam logic [5:0] REG_IND      = 6'd17;

  // Palette byte pair -> {R,B,G}: first byte carries R in [6:4], B in [2:0].
  function automatic logic [8:0] pal_pack(input logic [5:0] rb, input logic [2:0] g);
    return {rb, g};
  endfunction

endpackage

// File: rtl/vdp_port_decoder_if.sv
// CPU-bus, register-file, palette and VRAM signals of the VDP port decoder.
interface vdp_port_decoder_if #(parameter int VRAM_AW = vdp_io_pkg::VRAM_AW_DEF);
  logic               io_req;
  logic               io_wr;
  logic [1:0]         io_port;
  logic [7:0]         io_data;
  logic [7:0]         rd_data;
  logic               reg_wr;
  logic [5:0]         reg_num;
  logic [7:0]         reg_val;
  logic               status_rd;
  logic [3:0]         status_sel;
  logic [7:0]         status_data;
  logic               pal_wr;
  logic [3:0]         pal_idx;
  logic [8:0]         pal_data;
  logic               vram_req;
  logic               vram_we;
  logic [VRAM_AW-1:0] vram_addr;
  logic [7:0]         vram_wdata;
  logic               vram_ack;
  logic [7:0]         vram_rdata;
  logic               overrun;

  modport slave (
    input  io_req, io_wr, io_port, io_data, status_data, vram_ack, vram_rdata,
    output rd_data, reg_wr, reg_num, reg_val, status_rd, status_sel,
           pal_wr, pal_idx, pal_data, vram_req, vram_we, vram_addr, vram_wdata, overrun
  );

  modport master (
    output io_req, io_wr, io_port, io_data, status_data, vram_ack, vram_rdata,
    input  rd_data, reg_wr, reg_num, reg_val, status_rd, status_sel,
           pal_wr, pal_idx, pal_data, vram_req, vram_we, vram_addr, vram_wdata, overrun
  );
endinterface

// File: rtl/vdp_vram_queue.sv
// One in-flight VRAM request plus one pending slot; a push while both are held is dropped.
module vdp_vram_queue
  import vdp_io_pkg::*;
#(
  parameter int VRAM_AW = VRAM_AW_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               push,
  input  logic               push_we,
  input  logic [VRAM_AW-1:0] push_addr,
  input  logic [7:0]         push_wdata,
  input  logic               vram_ack,
  output logic               vram_req,
  output logic               vram_we,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic [7:0]         vram_wdata,
  output logic               overrun
);

  logic               pend_v;
  logic               pend_we;
  logic [VRAM_AW-1:0] pend_addr;
  logic [7:0]         pend_wdata;
  logic               act_free;

  // The acked slot counts as free in its ack cycle, so a push there is never dropped.
  assign act_free = !vram_req || vram_ack;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vram_req   <= 1'b0;
      vram_we    <= 1'b0;
      vram_addr  <= '0;
      vram_wdata <= '0;
      pend_v     <= 1'b0;
      pend_we    <= 1'b0;
      pend_addr  <= '0;
      pend_wdata <= '0;
      overrun    <= 1'b0;
    end else if (act_free) begin
      if (pend_v) begin
        vram_req   <= 1'b1;
        vram_we    <= pend_we;
        vram_addr  <= pend_addr;
        vram_wdata <= pend_wdata;
        pend_v     <= push;
        if (push) begin
          pend_we    <= push_we;
          pend_addr  <= push_addr;
          pend_wdata <= push_wdata;
        end
      end else begin
        vram_req <= push;
        if (push) begin
          vram_we    <= push_we;
          vram_addr  <= push_addr;
          vram_wdata <= push_wdata;
        end
      end
    end else if (push) begin
      if (!pend_v) begin
        pend_v     <= 1'b1;
        pend_we    <= push_we;
        pend_addr  <= push_addr;
        pend_wdata <= push_wdata;
      end else begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/vdp_port_decoder.sv
// VDP port protocol: two-byte control writes, VRAM data stream, palette pairs, indirect registers.
module vdp_port_decoder
  import vdp_io_pkg::*;
#(
  parameter int VRAM_AW = VRAM_AW_DEF
) (
  input logic               clk,
  input logic               reset_n,
  vdp_port_decoder_if.slave bus
);

  localparam int HW = VRAM_AW - 14;

  logic               ctl_ff, pal_ff;
  logic [7:0]         ctl_latch;
  logic [5:0]         pal_latch;
  logic [13:0]        ptr_lo;
  logic [HW-1:0]      r14_hi;
  logic [3:0]         r15_sel, r16_idx;
  logic [5:0]         r17_ptr;
  logic               r17_hold;
  logic [7:0]         rd_buf;

  logic [7:0]         rd_data_q, reg_val_q;
  logic               reg_wr_q, status_rd_q, pal_wr_q;
  logic [5:0]         reg_num_q;
  logic [3:0]         pal_idx_q;
  logic [8:0]         pal_data_q;

  vdp_port_e          port;
  logic               wr, rd, ctl_2nd, is_setup, is_regw1, is_ind;
  logic               push, push_we, ptr_upd, rw_en, ack_rd;
  logic [VRAM_AW-1:0] ptr_base, ptr_nxt;
  logic [5:0]         rw_num;
  logic [7:0]         rw_val;

  logic               q_req, q_we, q_ovr;
  logic [VRAM_AW-1:0] q_addr;
  logic [7:0]         q_wdata;

  always_comb begin
    port     = vdp_port_e'(bus.io_port);
    wr       = bus.io_req & bus.io_wr;
    rd       = bus.io_req & ~bus.io_wr;
    ctl_2nd  = wr && port == PORT_CTRL && ctl_ff;
    is_regw1 = ctl_2nd && bus.io_data[7];
    is_setup = ctl_2nd && !bus.io_data[7];
    is_ind   = wr && port == PORT_IND;
    push_we  = wr && port == PORT_DATA;
    // Read-setup (bit6=0) prefetches the new address and steps past it.
    push     = (bus.io_req && port == PORT_DATA) || (is_setup && !bus.io_data[6]);
    ptr_upd  = (bus.io_req && port == PORT_DATA) || is_setup;
    ptr_base = is_setup ? {r14_hi, bus.io_data[5:0], ctl_latch} : {r14_hi, ptr_lo};
    ptr_nxt  = push ? ptr_base + VRAM_AW'(1) : ptr_base;
    rw_en    = is_regw1 || (is_ind && r17_ptr != REG_IND);
    rw_num   = is_regw1 ? bus.io_data[5:0] : r17_ptr;
    rw_val   = is_regw1 ? ctl_latch : bus.io_data;
    ack_rd   = bus.vram_ack && q_req && !q_we;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctl_ff      <= 1'b0;
      pal_ff      <= 1'b0;
      ctl_latch   <= '0;
      pal_latch   <= '0;
      ptr_lo      <= '0;
      r14_hi      <= '0;
      r15_sel     <= '0;
      r16_idx     <= '0;
      r17_ptr     <= '0;
      r17_hold    <= 1'b0;
      rd_buf      <= '0;
      rd_data_q   <= '0;
      reg_wr_q    <= 1'b0;
      reg_num_q   <= '0;
      reg_val_q   <= '0;
      status_rd_q <= 1'b0;
      pal_wr_q    <= 1'b0;
      pal_idx_q   <= '0;
      pal_data_q  <= '0;
    end else begin
      reg_wr_q    <= 1'b0;
      pal_wr_q    <= 1'b0;
      status_rd_q <= 1'b0;
      if (ack_rd) rd_buf <= bus.vram_rdata;
      // Carry out of the low 14 bits lands in the R#14 shadow.
      if (ptr_upd) begin
        ptr_lo <= ptr_nxt[13:0];
        r14_hi <= ptr_nxt[VRAM_AW-1:14];
      end
      if (bus.io_req) begin
        case (port)
          PORT_DATA: begin
            ctl_ff <= 1'b0;
            if (rd) rd_data_q <= ack_rd ? bus.vram_rdata : rd_buf;
          end
          PORT_CTRL: begin
            if (wr) begin
              ctl_ff <= ~ctl_ff;
              if (!ctl_ff) ctl_latch <= bus.io_data;
            end else begin
              rd_data_q   <= bus.status_data;
              status_rd_q <= 1'b1;
              ctl_ff      <= 1'b0;
            end
          end
          PORT_PAL: begin
            if (wr) begin
              if (!pal_ff) begin
                pal_latch <= {bus.io_data[6:4], bus.io_data[2:0]};
                pal_ff    <= 1'b1;
              end else begin
                pal_wr_q   <= 1'b1;
                pal_idx_q  <= r16_idx;
                pal_data_q <= pal_pack(pal_latch, bus.io_data[2:0]);
                r16_idx    <= r16_idx + 4'd1;
                pal_ff     <= 1'b0;
              end
            end else begin
              rd_data_q <= 8'hFF;
            end
          end
          PORT_IND: begin
            if (wr) begin
              if (!r17_hold) r17_ptr <= r17_ptr + 6'd1;
            end else begin
              rd_data_q <= 8'hFF;
            end
          end
          default: ;
        endcase
      end
      if (rw_en) begin
        reg_wr_q  <= 1'b1;
        reg_num_q <= rw_num;
        reg_val_q <= rw_val;
        case (rw_num)
          REG_ADDR_HI:  r14_hi  <= rw_val[HW-1:0];
          REG_STAT_SEL: r15_sel <= rw_val[3:0];
          REG_PAL_IDX: begin
            r16_idx <= rw_val[3:0];
            pal_ff  <= 1'b0;
          end
          REG_IND: begin
            r17_ptr  <= rw_val[5:0];
            r17_hold <= rw_val[7];
          end
          default: ;
        endcase
      end
    end
  end

  vdp_vram_queue #(.VRAM_AW(VRAM_AW)) u_vq (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .push_we    (push_we),
    .push_addr  (ptr_base),
    .push_wdata (bus.io_data),
    .vram_ack   (bus.vram_ack),
    .vram_req   (q_req),
    .vram_we    (q_we),
    .vram_addr  (q_addr),
    .vram_wdata (q_wdata),
    .overrun    (q_ovr)
  );

  assign bus.rd_data    = rd_data_q;
  assign bus.reg_wr     = reg_wr_q;
  assign bus.reg_num    = reg_num_q;
  assign bus.reg_val    = reg_val_q;
  assign bus.status_rd  = status_rd_q;
  assign bus.status_sel = r15_sel;
  assign bus.pal_wr     = pal_wr_q;
  assign bus.pal_idx    = pal_idx_q;
  assign bus.pal_data   = pal_data_q;
  assign bus.vram_req   = q_req;
  assign bus.vram_we    = q_we;
  assign bus.vram_addr  = q_addr;
  assign bus.vram_wdata = q_wdata;
  assign bus.overrun    = q_ovr;

endmodule

// File: tb/tb_vdp_port_decoder.sv
// Bench for vdp_port_decoder: directed protocol scenarios then random traffic against a queue model.
module tb_vdp_port_decoder;

  logic clk;
  logic reset_n;
  int   n_chk = 0;
  int   n_err = 0;
  int   ack_pct = 0;

  vdp_port_decoder_if #(.VRAM_AW(17)) bus();

  vdp_port_decoder #(.VRAM_AW(17)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  typedef struct {
    bit         we;
    int         addr;
    logic [7:0] wd;
  } vreq_t;

  vreq_t      mq[$];
  logic [7:0] m_regs[64];
  int         m_ptr;
  bit         m_ctl, m_pal_ff, m_ovr;
  logic [7:0] m_latch, m_platch, m_rbuf, m_rd;
  bit         m_reg_wr, m_pal_wr, m_status_rd;
  int         m_reg_num, m_reg_val, m_pal_idx, m_pal_data;

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 64; i++) m_regs[i] = 8'h00;
    m_ptr = 0; m_ctl = 0; m_pal_ff = 0; m_ovr = 0;
    m_latch = 0; m_platch = 0; m_rbuf = 0; m_rd = 0;
    m_reg_wr = 0; m_pal_wr = 0; m_status_rd = 0;
    m_reg_num = 0; m_reg_val = 0; m_pal_idx = 0; m_pal_data = 0;
  endtask

  task automatic m_push(input bit we, input logic [7:0] wd);
    vreq_t r;
    r.we = we; r.addr = m_ptr; r.wd = wd;
    if (mq.size() < 2) mq.push_back(r);
    else m_ovr = 1'b1;
    m_ptr = (m_ptr + 1) % 32'h20000;
    m_regs[14][2:0] = 3'(m_ptr >> 14);
  endtask

  task automatic m_regw(input int n, input logic [7:0] v);
    m_reg_wr = 1; m_reg_num = n; m_reg_val = int'(v);
    m_regs[n] = v;
    if (n == 14) m_ptr = (int'(v[2:0]) << 14) | (m_ptr & 32'h3FFF);
    if (n == 16) m_pal_ff = 0;
  endtask

  task automatic model_step();
    logic [7:0] d;
    int n;
    m_reg_wr = 0; m_pal_wr = 0; m_status_rd = 0;
    if (bus.vram_ack && mq.size() > 0) begin
      if (!mq[0].we) m_rbuf = bus.vram_rdata;
      mq.delete(0);
    end
    if (bus.io_req) begin
      d = bus.io_data;
      if (bus.io_wr) begin
        case (int'(bus.io_port))
          0: begin m_ctl = 0; m_push(1'b1, d); end
          1: begin
            if (!m_ctl) begin m_latch = d; m_ctl = 1; end
            else begin
              m_ctl = 0;
              if (d[7]) m_regw(int'(d[5:0]), m_latch);
              else begin
                m_ptr = (int'(m_regs[14][2:0]) << 14) | (int'(d[5:0]) << 8) | int'(m_latch);
                if (!d[6]) m_push(1'b0, 8'h00);
              end
            end
          end
          2: begin
            if (!m_pal_ff) begin m_platch = d; m_pal_ff = 1; end
            else begin
              m_pal_wr = 1;
              m_pal_idx = int'(m_regs[16][3:0]);
              m_pal_data = int'(m_platch[6:4]) * 64 + int'(m_platch[2:0]) * 8 + int'(d[2:0]);
              m_regs[16][3:0] = 4'(m_pal_idx + 1);
              m_pal_ff = 0;
            end
          end
          default: begin
            n = int'(m_regs[17][5:0]);
            if (n != 17) m_regw(n, d);
            if (!m_regs[17][7]) m_regs[17][5:0] = 6'(n + 1);
          end
        endcase
      end else begin
        case (int'(bus.io_port))
          0: begin m_ctl = 0; m_rd = m_rbuf; m_push(1'b0, 8'h00); end
          1: begin m_rd = bus.status_data; m_status_rd = 1; m_ctl = 0; end
          default: m_rd = 8'hFF;
        endcase
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("rd_data", 32'(bus.rd_data), 32'(m_rd));
    chk("reg_wr", 32'(bus.reg_wr), 32'(m_reg_wr));
    if (m_reg_wr) begin
      chk("reg_num", 32'(bus.reg_num), m_reg_num);
      chk("reg_val", 32'(bus.reg_val), m_reg_val);
    end
    chk("status_rd", 32'(bus.status_rd), 32'(m_status_rd));
    chk("status_sel", 32'(bus.status_sel), 32'(m_regs[15][3:0]));
    chk("pal_wr", 32'(bus.pal_wr), 32'(m_pal_wr));
    if (m_pal_wr) begin
      chk("pal_idx", 32'(bus.pal_idx), m_pal_idx);
      chk("pal_data", 32'(bus.pal_data), m_pal_data);
    end
    chk("vram_req", 32'(bus.vram_req), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("vram_we", 32'(bus.vram_we), 32'(mq[0].we));
      chk("vram_addr", 32'(bus.vram_addr), mq[0].addr);
      if (mq[0].we) chk("vram_wdata", 32'(bus.vram_wdata), 32'(mq[0].wd));
    end
    chk("overrun", 32'(bus.overrun), 32'(m_ovr));
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge, next defaults driven.
  task automatic cycle();
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_step();
    @(negedge clk);
    compare();
    #1;
    bus.io_req      = 1'b0;
    bus.status_data = 8'($urandom);
    bus.vram_rdata  = 8'($urandom);
    bus.vram_ack    = (ack_pct > 0) && (mq.size() > 0) && ($urandom_range(0, 99) < ack_pct);
  endtask

  task automatic io(input bit w, input int p, input int d);
    bus.io_req  = 1'b1;
    bus.io_wr   = w;
    bus.io_port = 2'(p);
    bus.io_data = 8'(d);
    cycle();
  endtask

  task automatic ack1(input int rdata);
    bus.vram_ack   = 1'b1;
    bus.vram_rdata = 8'(rdata);
    cycle();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_vram_req", 32'(bus.vram_req), 32'd0);
    chk("rst_overrun", 32'(bus.overrun), 32'd0);
    model_reset();
    cycle();
    cycle();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    bus.io_req = 1'b0; bus.io_wr = 1'b0; bus.io_port = 2'd0; bus.io_data = 8'h00;
    bus.status_data = 8'h00; bus.vram_ack = 1'b0; bus.vram_rdata = 8'h00;
    model_reset();
    repeat (2) cycle();
    reset_n = 1'b1;
    cycle();
    chk("lit_reset_rd_data", 32'(bus.rd_data), 32'h0);
    chk("lit_reset_vram_req", 32'(bus.vram_req), 32'h0);
    chk("lit_reset_reg_wr", 32'(bus.reg_wr), 32'h0);

    // Two-byte register write
    io(1, 1, 8'h07);
    chk("lit_reg_wr_early", 32'(bus.reg_wr), 32'h0);
    io(1, 1, 8'h87);
    chk("lit_reg_wr", 32'(bus.reg_wr), 32'h1);
    chk("lit_reg_num", 32'(bus.reg_num), 32'd7);
    chk("lit_reg_val", 32'(bus.reg_val), 32'h07);

    // R#14=1, write setup 0x0000, two data writes
    io(1, 1, 8'h01); io(1, 1, 8'h8E);
    io(1, 1, 8'h00); io(1, 1, 8'h40);
    io(1, 0, 8'hAA);
    chk("lit_wr1_addr", 32'(bus.vram_addr), 32'h04000);
    chk("lit_wr1_data", 32'(bus.vram_wdata), 32'hAA);
    io(1, 0, 8'hBB);
    cycle(); cycle();
    ack1(0);
    chk("lit_wr2_addr", 32'(bus.vram_addr), 32'h04001);
    chk("lit_wr2_data", 32'(bus.vram_wdata), 32'hBB);
    ack1(0);
    chk("lit_wr_idle", 32'(bus.vram_req), 32'h0);
    chk("lit_wr_no_ovr", 32'(bus.overrun), 32'h0);

    // Full-width pointer wrap
    io(1, 1, 8'h07); io(1, 1, 8'h8E);
    io(1, 1, 8'hFF); io(1, 1, 8'h7F);
    io(1, 0, 8'h11);
    chk("lit_wrap_top", 32'(bus.vram_addr), 32'h1FFFF);
    ack1(0);
    io(1, 0, 8'h22);
    chk("lit_wrap_zero", 32'(bus.vram_addr), 32'h00000);
    ack1(0);

    // Read setup prefetch then port-0 read
    io(1, 1, 8'h34); io(1, 1, 8'h12);
    chk("lit_pf_addr", 32'(bus.vram_addr), 32'h01234);
    chk("lit_pf_we", 32'(bus.vram_we), 32'h0);
    ack1(8'h5A);
    io(0, 0, 0);
    chk("lit_rd_data", 32'(bus.rd_data), 32'h5A);
    chk("lit_pf2_addr", 32'(bus.vram_addr), 32'h01235);
    ack1(8'h00);

    // Palette pair at index F, then wrap to 0
    io(1, 1, 8'h0F); io(1, 1, 8'h90);
    io(1, 2, 8'h72); io(1, 2, 8'h05);
    chk("lit_pal_wr", 32'(bus.pal_wr), 32'h1);
    chk("lit_pal_idx", 32'(bus.pal_idx), 32'hF);
    chk("lit_pal_data", 32'(bus.pal_data), 32'h1D5);
    io(1, 2, 8'h00); io(1, 2, 8'h00);
    chk("lit_pal_idx_wrap", 32'(bus.pal_idx), 32'h0);

    // Indirect register pointer wrap 63 -> 0
    io(1, 1, 8'h3F); io(1, 1, 8'h91);
    io(1, 3, 8'h11);
    chk("lit_ind_num63", 32'(bus.reg_num), 32'd63);
    chk("lit_ind_val", 32'(bus.reg_val), 32'h11);
    io(1, 3, 8'h22);
    chk("lit_ind_num0", 32'(bus.reg_num), 32'd0);

    // Overrun with ack held low
    io(1, 0, 8'h01); io(1, 0, 8'h02);
    chk("lit_ovr_before", 32'(bus.overrun), 32'h0);
    io(1, 0, 8'h03);
    chk("lit_ovr_after", 32'(bus.overrun), 32'h1);
    chk("lit_req_high", 32'(bus.vram_req), 32'h1);

    // Asynchronous reset drops the outstanding request
    do_reset();
    cycle();

    // Random traffic with random acks
    ack_pct = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      if ($urandom_range(0, 99) < 60) begin
        bus.io_req  = 1'b1;
        bus.io_wr   = 1'($urandom);
        bus.io_port = 2'($urandom);
        bus.io_data = 8'($urandom);
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
